// File: rtl/cond_pkg.sv
// Shared constants for the condition unit: condition codes, flag bit
// positions and flag-write group selectors.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the ascending-order {V,C,N,Z} flag vector.
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    localparam int FW_NZ = 0;
    localparam int FW_CV = 1;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: (cond, flags) -> cond_ex.
// Carry follows the "C = 1 means no borrow" subtract convention.
module cond_check
    import cond_pkg::*;
(
    input  logic [0:3] cond,
    input  logic [0:3] flags,
    output logic       cond_ex
);

    logic v, c, n, z;

    always_comb begin
        v       = flags[FLAG_V];
        c       = flags[FLAG_C];
        n       = flags[FLAG_N];
        z       = flags[FLAG_Z];
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;  // reserved code never executes
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: architectural flag register, condition evaluation and
// write-strobe gating. Optional saturating statistics via COND_UNIT_STATS_EN.
module cond_unit
    import cond_pkg::*;
#(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:3]        ALUFlags,
    input  logic [0:1]        FlagW,
    input  logic [0:3]        Cond,
    input  logic              InstrValid,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              PCS,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              PCSrc,
    output logic              CondEx,
    output logic [0:3]        Flags,
    output logic [0:STAT_W-1] TakenCount,
    output logic [0:STAT_W-1] SkipCount
);

    logic [0:3] flags_q;
    logic       cond_ex;
    logic       fire;

    // Evaluated on the registered flags, so a same-cycle flag write is not seen.
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign fire     = cond_ex & InstrValid & !reset;
    assign CondEx   = cond_ex;
    assign RegWrite = RegW & fire;
    assign MemWrite = MemW & fire;
    assign PCSrc    = PCS  & fire;
    assign Flags    = flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (fire) begin
            if (FlagW[FW_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FW_CV]) begin
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
            end
        end
    end

`ifdef COND_UNIT_STATS_EN
    logic [0:STAT_W-1] taken_q;
    logic [0:STAT_W-1] skip_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= '0;
            skip_q  <= '0;
        end else begin
            if (PCSrc && (taken_q != '1))
                taken_q <= taken_q + STAT_W'(1);
            if (InstrValid && !cond_ex && (skip_q != '1))
                skip_q <= skip_q + STAT_W'(1);
        end
    end

    assign TakenCount = taken_q;
    assign SkipCount  = skip_q;
`else
    assign TakenCount = '0;
    assign SkipCount  = '0;
`endif

endmodule
